npu_seq: RTL and testbench

Command-driven sequencer for `npu_top`. It takes one layer command, writes the 16-bit SSFR configuration, and streams input beats into the NPU with `EN_FSM` strobes. It then reads back a fixed number of result bytes through `RD_EN`/`D_OUT` onto a valid/ready output stream. It sits between the host/DMA side and `npu_top`, and is the only driver of the NPU control inputs.

---
 rtl/npu_seq_pkg.sv | 24 ++
 rtl/npu_seq_drain.sv | 87 ++++++++
 rtl/npu_seq.sv | 178 +++++++++++++++++
 tb/tb_npu_seq.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_seq_pkg.sv
// Shared types and constants for the npu_seq command sequencer.
package npu_seq_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCfg   = 3'd1,
    StLoad  = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } npu_seq_state_t;

  localparam int unsigned CntWDefault = 16;

  // Byte-lane positions of the NPU data buses inside a 32-bit input beat.
  localparam int unsigned LaneDa = 3;
  localparam int unsigned LaneDb = 2;
  localparam int unsigned LaneDc = 1;
  localparam int unsigned LaneDd = 0;

  function automatic logic [7:0] get_lane(logic [31:0] word, int unsigned idx);
    return word[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/npu_seq_drain.sv
// Result drain: issues RD_EN reads, holds one byte for the output stream and counts accepts.
module npu_seq_drain
  import npu_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             active_i,
  input  logic [CNT_W-1:0] n_out_i,
  input  logic             empty_i,
  input  logic [7:0]       d_out_i,
  input  logic             out_ready_i,
  output logic             rd_en_o,
  output logic             out_valid_o,
  output logic [7:0]       out_data_o,
  output logic             last_accepted_o
);

  logic             rd_en_q, rd_en_d;
  logic             cap_q, cap_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_fire;
  logic             slot_free;
  logic             issue;

  assign out_fire  = out_valid_q & out_ready_i;
  // The holding register counts as free in the cycle its byte is taken, so the
  // refill read can launch immediately and the drain sustains one byte per 3 cycles.
  assign slot_free = ~out_valid_q | out_ready_i;
  assign issue     = active_i & ~empty_i & ~rd_en_q & ~cap_q & slot_free & (rd_cnt_q < n_out_i);

  always_comb begin
    rd_en_d     = issue;
    cap_d       = rd_en_q;
    rd_cnt_d    = rd_cnt_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (start_i) begin
      rd_cnt_d  = '0;
      out_cnt_d = '0;
    end else begin
      if (issue) begin
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end
      if (out_fire) begin
        out_cnt_d = out_cnt_q + CNT_W'(1);
      end
    end
    // D_OUT is valid the cycle after RD_EN.
    if (cap_q) begin
      out_valid_d = 1'b1;
      out_data_d  = d_out_i;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_en_q     <= 1'b0;
      cap_q       <= 1'b0;
      rd_cnt_q    <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      rd_en_q     <= rd_en_d;
      cap_q       <= cap_d;
      rd_cnt_q    <= rd_cnt_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign rd_en_o         = rd_en_q;
  assign out_valid_o     = out_valid_q;
  assign out_data_o      = out_data_q;
  assign last_accepted_o = out_fire & ((out_cnt_q + CNT_W'(1)) == n_out_i);

endmodule

// File: rtl/npu_seq.sv
// Command sequencer for npu_top: config write, input beat streaming, result drain.
module npu_seq
  import npu_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             CLKEXT,
  input  logic             RST_GLO,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_cfg,
  input  logic [CNT_W-1:0] cmd_n_in,
  input  logic [CNT_W-1:0] cmd_n_out,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy,
  output logic             done,
  output logic             EN_CONFIG,
  output logic             EN_FSM,
  output logic             RD_EN,
  output logic             SEL_CON,
  output logic [7:0]       DA,
  output logic [7:0]       DB,
  output logic [7:0]       DC,
  output logic [7:0]       DD,
  input  logic [7:0]       D_OUT,
  input  logic             FULL,
  input  logic             EMPTY
);

  npu_seq_state_t state_q, state_d;

  logic [15:0]      cfg_q, cfg_d;
  logic [CNT_W-1:0] n_in_q, n_in_d;
  logic [CNT_W-1:0] n_out_q, n_out_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic             en_fsm_q, en_fsm_d;
  logic [31:0]      beat_q, beat_d;

  logic cmd_fire;
  logic in_fire;
  logic last_beat;
  logic last_accepted;

  assign cmd_fire  = cmd_valid & (state_q == StIdle);
  assign in_ready  = (state_q == StLoad) & ~FULL & (in_cnt_q < n_in_q);
  assign in_fire   = in_valid & in_ready;
  assign last_beat = in_fire & ((in_cnt_q + CNT_W'(1)) == n_in_q);

  // State register.
  always_ff @(posedge CLKEXT) begin
    if (RST_GLO) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = StCfg;
        end
      end
      StCfg: begin
        if (n_in_q != '0) begin
          state_d = StLoad;
        end else if (n_out_q != '0) begin
          state_d = StDrain;
        end else begin
          state_d = StDone;
        end
      end
      StLoad: begin
        if (last_beat) begin
          state_d = (n_out_q != '0) ? StDrain : StDone;
        end
      end
      StDrain: begin
        if (last_accepted) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs; the beat strobe trails its handshake by one cycle and never overlaps CFG.
  always_comb begin
    cmd_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    EN_CONFIG = (state_q == StCfg);
    EN_FSM    = en_fsm_q;
    SEL_CON   = 1'b1;
    DA        = '0;
    DB        = '0;
    DC        = '0;
    DD        = '0;
    if (state_q == StCfg) begin
      DA = cfg_q[15:8];
      DB = cfg_q[7:0];
    end else if (en_fsm_q) begin
      DA = get_lane(beat_q, LaneDa);
      DB = get_lane(beat_q, LaneDb);
      DC = get_lane(beat_q, LaneDc);
      DD = get_lane(beat_q, LaneDd);
    end
  end

  always_comb begin
    cfg_d    = cfg_q;
    n_in_d   = n_in_q;
    n_out_d  = n_out_q;
    in_cnt_d = in_cnt_q;
    en_fsm_d = in_fire;
    beat_d   = beat_q;
    if (cmd_fire) begin
      cfg_d    = cmd_cfg;
      n_in_d   = cmd_n_in;
      n_out_d  = cmd_n_out;
      in_cnt_d = '0;
    end else if (in_fire) begin
      in_cnt_d = in_cnt_q + CNT_W'(1);
    end
    if (in_fire) begin
      beat_d = in_data;
    end
  end

  always_ff @(posedge CLKEXT) begin
    if (RST_GLO) begin
      cfg_q    <= '0;
      n_in_q   <= '0;
      n_out_q  <= '0;
      in_cnt_q <= '0;
      en_fsm_q <= 1'b0;
      beat_q   <= '0;
    end else begin
      cfg_q    <= cfg_d;
      n_in_q   <= n_in_d;
      n_out_q  <= n_out_d;
      in_cnt_q <= in_cnt_d;
      en_fsm_q <= en_fsm_d;
      beat_q   <= beat_d;
    end
  end

  npu_seq_drain #(
    .CNT_W (CNT_W)
  ) u_drain (
    .clk_i           (CLKEXT),
    .rst_i           (RST_GLO),
    .start_i         (state_q == StCfg),
    .active_i        (state_q == StDrain),
    .n_out_i         (n_out_q),
    .empty_i         (EMPTY),
    .d_out_i         (D_OUT),
    .out_ready_i     (out_ready),
    .rd_en_o         (RD_EN),
    .out_valid_o     (out_valid),
    .out_data_o      (out_data),
    .last_accepted_o (last_accepted)
  );

endmodule

// File: tb/tb_npu_seq.sv
// Scoreboard bench for npu_seq: randomized commands against a queue-based NPU/stream model.
module tb_npu_seq;

  logic        CLKEXT = 1'b0;
  logic        RST_GLO;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_cfg, cmd_n_in, cmd_n_out;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        busy, done;
  logic        EN_CONFIG, EN_FSM, RD_EN, SEL_CON;
  logic [7:0]  DA, DB, DC, DD, D_OUT;
  logic        FULL, EMPTY;

  npu_seq #(
    .CNT_W (16)
  ) dut (
    .CLKEXT    (CLKEXT),
    .RST_GLO   (RST_GLO),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_cfg   (cmd_cfg),
    .cmd_n_in  (cmd_n_in),
    .cmd_n_out (cmd_n_out),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .EN_CONFIG (EN_CONFIG),
    .EN_FSM    (EN_FSM),
    .RD_EN     (RD_EN),
    .SEL_CON   (SEL_CON),
    .DA        (DA),
    .DB        (DB),
    .DC        (DC),
    .DD        (DD),
    .D_OUT     (D_OUT),
    .FULL      (FULL),
    .EMPTY     (EMPTY)
  );

  always #5 CLKEXT = ~CLKEXT;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] cfg_exp[$];
  logic [31:0] beat_exp[$];
  logic [31:0] in_src[$];
  logic [7:0]  out_exp[$];
  logic [7:0]  npu_q[$];

  bit in_fire_s, cmd_fire_s, rd_req_s;
  bit in_rand, out_rand, empty_rand;
  int en_cfg_tot, en_fsm_tot, rd_tot, done_tot;
  int acc_cyc, done_cyc, outstanding;
  int s_cfg, s_fsm, s_rd, s_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples mid-cycle, pops expectations as the DUT presents them.
  initial begin
    en_cfg_tot = 0; en_fsm_tot = 0; rd_tot = 0; done_tot = 0;
    acc_cyc = 0; done_cyc = 0; outstanding = 0;
    forever begin
      @(negedge CLKEXT);
      cyc++;
      if (RST_GLO) begin
        in_fire_s = 0; cmd_fire_s = 0; rd_req_s = 0;
        cfg_exp.delete(); beat_exp.delete(); in_src.delete();
        out_exp.delete(); npu_q.delete();
        outstanding = 0;
      end else begin
        in_fire_s  = in_valid & in_ready;
        cmd_fire_s = cmd_valid & cmd_ready;
        rd_req_s   = RD_EN;
        if (cmd_fire_s) acc_cyc = cyc;
        chk("sel_con", {31'd0, SEL_CON}, 32'd1);
        if (FULL) chk("in_ready_while_full", {31'd0, in_ready}, 32'd0);
        if (EN_CONFIG) begin
          en_cfg_tot++;
          chk("cfg_cycle", cyc, acc_cyc + 1);
          chk("cfg_expected", cfg_exp.size() > 0, 1);
          if (cfg_exp.size() > 0) chk("cfg_lanes", {DA, DB, DC, DD}, {cfg_exp.pop_front(), 16'h0});
        end else if (EN_FSM) begin
          en_fsm_tot++;
          chk("beat_expected", beat_exp.size() > 0, 1);
          if (beat_exp.size() > 0) chk("beat_lanes", {DA, DB, DC, DD}, beat_exp.pop_front());
        end else begin
          chk("bus_idle", {DA, DB, DC, DD}, 32'h0);
        end
        if (RD_EN) begin
          rd_tot++;
          outstanding++;
          chk("reads_outstanding_le1", outstanding <= 1, 1);
        end
        if (out_valid) begin
          chk("out_expected", out_exp.size() > 0, 1);
          if (out_exp.size() > 0) begin
            chk("out_data", {24'd0, out_data}, {24'd0, out_exp[0]});
            if (out_ready) begin
              void'(out_exp.pop_front());
              outstanding--;
            end
          end
        end
        if (done) begin
          done_tot++;
          done_cyc = cyc;
        end
      end
    end
  end

  // Input stream driver.
  initial begin
    in_valid = 0;
    in_data  = '0;
    forever begin
      @(posedge CLKEXT);
      #1;
      if (in_fire_s && in_src.size() > 0) void'(in_src.pop_front());
      if (in_src.size() > 0 && (!in_rand || $urandom_range(0, 3) != 0)) begin
        in_valid = 1;
        in_data  = in_src[0];
      end else begin
        in_valid = 0;
        in_data  = '0;
      end
    end
  end

  // Output sink.
  initial begin
    out_ready = 1;
    forever begin
      @(posedge CLKEXT);
      #1;
      out_ready = out_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // NPU result buffer: byte appears on D_OUT the cycle after RD_EN.
  initial begin
    D_OUT = '0;
    EMPTY = 1;
    forever begin
      @(posedge CLKEXT);
      #1;
      if (rd_req_s) D_OUT = (npu_q.size() > 0) ? npu_q.pop_front() : 8'hEE;
      EMPTY = (npu_q.size() == 0) || (empty_rand && $urandom_range(0, 2) == 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLKEXT);
      #1;
    end
  endtask

  task automatic snap();
    s_cfg = en_cfg_tot; s_fsm = en_fsm_tot; s_rd = rd_tot; s_done = done_tot;
  endtask

  task automatic issue(input logic [15:0] cfg, input int nin, input int nout);
    logic [31:0] w;
    logic [7:0]  b;
    cfg_exp.push_back(cfg);
    for (int i = 0; i < nin; i++) begin
      w = $urandom;
      in_src.push_back(w);
      beat_exp.push_back(w);
    end
    for (int i = 0; i < nout; i++) begin
      b = 8'($urandom_range(0, 255));
      npu_q.push_back(b);
      out_exp.push_back(b);
    end
    cmd_cfg   = cfg;
    cmd_n_in  = 16'(nin);
    cmd_n_out = 16'(nout);
    cmd_valid = 1;
  endtask

  task automatic wait_accept(input bit hold, input int bound);
    int t = 0;
    do begin
      tick(1);
      t++;
    end while (!cmd_fire_s && t < bound);
    chk("cmd_accept_timeout", {31'd0, cmd_fire_s}, 32'd1);
    if (!hold) cmd_valid = 0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_tot < target && t < 3000) begin
      tick(1);
      t++;
    end
    chk("done_timeout", done_tot >= target, 1);
  endtask

  task automatic finish_cmd(input int nin, input int nout);
    wait_done(s_done + 1);
    tick(2);
    chk("en_config_count", en_cfg_tot - s_cfg, 1);
    chk("en_fsm_count", en_fsm_tot - s_fsm, nin);
    chk("rd_en_count", rd_tot - s_rd, nout);
    chk("done_count", done_tot - s_done, 1);
    chk("beats_left", beat_exp.size(), 0);
    chk("bytes_left", out_exp.size(), 0);
  endtask

  task automatic run(input logic [15:0] cfg, input int nin, input int nout);
    snap();
    issue(cfg, nin, nout);
    wait_accept(0, 50);
    finish_cmd(nin, nout);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    RST_GLO = 1; cmd_valid = 0; cmd_cfg = '0; cmd_n_in = '0; cmd_n_out = '0; FULL = 0;
    in_rand = 0; out_rand = 0; empty_rand = 0;
    tick(3);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_strobes", {29'd0, EN_CONFIG, EN_FSM, RD_EN}, 32'd0);
    chk("rst_sel_con", {31'd0, SEL_CON}, 32'd1);
    chk("rst_buses", {DA, DB, DC, DD}, 32'h0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    RST_GLO = 0;
    tick(2);

    // Basic command.
    run(16'hA55A, 3, 2);

    // Input backpressure: FULL held for 4 cycles mid-LOAD.
    snap();
    issue(16'h1234, 12, 1);
    wait_accept(0, 50);
    tick(2);
    FULL = 1;
    tick(4);
    FULL = 0;
    chk("beats_pending_after_full", beat_exp.size() > 0, 1);
    finish_cmd(12, 1);

    // Output backpressure.
    out_rand = 1;
    run(16'h0F0F, 2, 6);
    out_rand = 0;

    // Zero counts.
    run(16'h00FF, 0, 0);
    chk("zero_done_latency", done_cyc - acc_cyc, 2);

    // Reset one cycle after the first RD_EN.
    snap();
    issue(16'hBEEF, 2, 3);
    wait_accept(0, 50);
    t = 0;
    while (rd_tot == s_rd && t < 200) begin
      tick(1);
      t++;
    end
    chk("rd_before_reset", rd_tot > s_rd, 1);
    RST_GLO = 1;
    tick(1);
    RST_GLO = 0;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_sel_con", {31'd0, SEL_CON}, 32'd1);
    chk("abort_strobes", {29'd0, EN_CONFIG, EN_FSM, RD_EN}, 32'd0);
    tick(1);
    run(16'h5AA5, 4, 3);

    // Busy rejection: cmd_valid held through the first command.
    snap();
    issue(16'h1111, 2, 2);
    wait_accept(1, 50);
    issue(16'h2222, 1, 1);
    wait_accept(0, 300);
    chk("busy_second_accept", acc_cyc, done_cyc + 1);
    chk("busy_first_done", done_tot - s_done, 1);
    wait_done(s_done + 2);
    tick(2);
    chk("busy_cfg_count", en_cfg_tot - s_cfg, 2);
    chk("busy_fsm_count", en_fsm_tot - s_fsm, 3);
    chk("busy_rd_count", rd_tot - s_rd, 3);
    chk("busy_bytes_left", out_exp.size(), 0);

    // Randomized commands with random stalls everywhere.
    in_rand = 1; out_rand = 1; empty_rand = 1;
    for (int i = 0; i < 12; i++) begin
      run(16'($urandom), $urandom_range(0, 6), $urandom_range(0, 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
